// File: rtl/uio_bot_bridge.sv
// rtl/uio_bot_bridge.sv - bottom-edge UIO bridge with egress/ingress FWFT FIFOs (overflow sticky under UIO_BOT_BRIDGE_OVF_EN)
module uio_bot_bridge #(
  parameter int EGRESS_DEPTH  = 8,
  parameter int INGRESS_DEPTH = 8
) (
  input  logic        UserCLK,
  input  logic        resetn,
  input  logic [19:0] UIO_BOT_FIN,
  output logic [19:0] UIO_BOT_FOUT,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam int EAW = $clog2(EGRESS_DEPTH);
  localparam int ECW = EAW + 1;
  localparam int IAW = $clog2(INGRESS_DEPTH);
  localparam int ICW = IAW + 1;

  // egress: fabric -> host
  logic [15:0]    e_mem_q [EGRESS_DEPTH];
  logic [EAW-1:0] e_rd_q, e_rd_d, e_wr_q, e_wr_d;
  logic [ECW-1:0] e_cnt_q, e_cnt_d;
  logic           e_full, e_empty, e_push, e_pop;

  // ingress: host -> fabric
  logic [15:0]    i_mem_q [INGRESS_DEPTH];
  logic [IAW-1:0] i_rd_q, i_rd_d, i_wr_q, i_wr_d;
  logic [ICW-1:0] i_cnt_q, i_cnt_d;
  logic           i_empty, i_push, i_pop;
  logic           in_ready_q, in_ready_d;
  logic [15:0]    i_head;
  logic           ovf;

  // full/empty come straight from the pre-edge count, so a push while full is
  // dropped even when the host drains a word in the same cycle
  assign e_full  = (e_cnt_q == ECW'(EGRESS_DEPTH));
  assign e_empty = (e_cnt_q == '0);
  assign e_push  = UIO_BOT_FIN[16] & ~e_full;
  assign e_pop   = ~e_empty & out_ready;

  assign i_empty = (i_cnt_q == '0);
  assign i_push  = in_valid & in_ready_q;
  assign i_pop   = UIO_BOT_FIN[17] & ~i_empty;

  // egress pointer and occupancy next-state
  always_comb begin
    e_rd_d  = e_rd_q;
    e_wr_d  = e_wr_q;
    e_cnt_d = e_cnt_q;
    if (e_push) e_wr_d = e_wr_q + EAW'(1);
    if (e_pop)  e_rd_d = e_rd_q + EAW'(1);
    case ({e_push, e_pop})
      2'b10:   e_cnt_d = e_cnt_q + ECW'(1);
      2'b01:   e_cnt_d = e_cnt_q - ECW'(1);
      default: e_cnt_d = e_cnt_q;
    endcase
  end

  // ingress pointer/occupancy next-state; in_ready looks at the next count so it is registered
  always_comb begin
    i_rd_d  = i_rd_q;
    i_wr_d  = i_wr_q;
    i_cnt_d = i_cnt_q;
    if (i_push) i_wr_d = i_wr_q + IAW'(1);
    if (i_pop)  i_rd_d = i_rd_q + IAW'(1);
    case ({i_push, i_pop})
      2'b10:   i_cnt_d = i_cnt_q + ICW'(1);
      2'b01:   i_cnt_d = i_cnt_q - ICW'(1);
      default: i_cnt_d = i_cnt_q;
    endcase
    in_ready_d = (i_cnt_d < ICW'(INGRESS_DEPTH));
  end

  // pointer, count and ready registers; reset discards both FIFOs
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      e_rd_q     <= '0;
      e_wr_q     <= '0;
      e_cnt_q    <= '0;
      i_rd_q     <= '0;
      i_wr_q     <= '0;
      i_cnt_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      e_rd_q     <= e_rd_d;
      e_wr_q     <= e_wr_d;
      e_cnt_q    <= e_cnt_d;
      i_rd_q     <= i_rd_d;
      i_wr_q     <= i_wr_d;
      i_cnt_q    <= i_cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  // storage arrays need no reset: stale words are unreachable once the pointers clear
  always_ff @(posedge UserCLK) begin
    if (e_push) e_mem_q[e_wr_q] <= UIO_BOT_FIN[15:0];
    if (i_push) i_mem_q[i_wr_q] <= in_data;
  end

`ifdef UIO_BOT_BRIDGE_OVF_EN
  logic ovf_q, ovf_d;
  logic unused_fin;
  assign unused_fin = UIO_BOT_FIN[19];

  // sticky overflow: a dropped fabric push sets it and beats a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    if (UIO_BOT_FIN[16] && e_full) ovf_d = 1'b1;
    else if (UIO_BOT_FIN[18])      ovf_d = 1'b0;
  end

  // overflow sticky register
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_fin;
  assign unused_fin = ^UIO_BOT_FIN[19:18];
  assign ovf        = 1'b0;
`endif

  // first-word-fall-through heads, forced to zero when empty
  assign out_data  = e_empty ? 16'h0000 : e_mem_q[e_rd_q];
  assign i_head    = i_empty ? 16'h0000 : i_mem_q[i_rd_q];
  assign out_valid = ~e_empty;
  assign in_ready  = in_ready_q;

  assign UIO_BOT_FOUT = {e_empty, ovf, ~i_empty, e_full, i_head};

endmodule

// File: tb/tb_uio_bot_bridge.sv
// tb/tb_uio_bot_bridge.sv - self-checking bench for uio_bot_bridge
module tb_uio_bot_bridge;

`ifdef UIO_BOT_BRIDGE_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [19:0] fin;
  logic [19:0] fout;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uio_bot_bridge #(.EGRESS_DEPTH(DEPTH), .INGRESS_DEPTH(DEPTH)) dut (
    .UserCLK     (clk),
    .resetn      (resetn),
    .UIO_BOT_FIN (fin),
    .UIO_BOT_FOUT(fout),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // behavioural model: two queues, a sticky bit and the registered ready
  logic [15:0] m_eq[$];
  logic [15:0] m_iq[$];
  logic        m_ovf      = 1'b0;
  logic        m_in_ready = 1'b0;
  logic [15:0] host_rx[$];
  logic [15:0] fab_rx[$];

  always @(posedge clk or negedge resetn) begin
    bit e_full, e_pop, e_push, i_pop, i_push;
    if (!resetn) begin
      m_eq.delete();
      m_iq.delete();
      m_ovf      = 1'b0;
      m_in_ready = 1'b0;
    end else begin
      if (out_valid && out_ready) host_rx.push_back(out_data);
      if (fin[17] && fout[17])    fab_rx.push_back(fout[15:0]);
      e_full = (m_eq.size() == DEPTH);
      e_pop  = (m_eq.size() != 0) && out_ready;
      e_push = fin[16] && !e_full;
      i_pop  = fin[17] && (m_iq.size() != 0);
      i_push = in_valid && m_in_ready;
      if (OVF_EN) begin
        if (fin[16] && e_full) m_ovf = 1'b1;
        else if (fin[18])      m_ovf = 1'b0;
      end
      if (e_pop)  void'(m_eq.pop_front());
      if (e_push) m_eq.push_back(fin[15:0]);
      if (i_pop)  void'(m_iq.pop_front());
      if (i_push) m_iq.push_back(in_data);
      m_in_ready = (m_iq.size() < DEPTH);
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [19:0] exp_fout;
    logic [15:0] exp_od;
    exp_od   = (m_eq.size() != 0) ? m_eq[0] : 16'h0000;
    exp_fout = {(m_eq.size() == 0), m_ovf, (m_iq.size() != 0), (m_eq.size() == DEPTH),
                (m_iq.size() != 0) ? m_iq[0] : 16'h0000};
    chk("cyc_fout", 32'(fout), 32'(exp_fout));
    chk("cyc_out_data", 32'(out_data), 32'(exp_od));
    chk("cyc_out_valid", 32'(out_valid), 32'(m_eq.size() != 0));
    chk("cyc_in_ready", 32'(in_ready), 32'(m_in_ready));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_q[$];
    int          found;

    fin       = '0;
    out_ready = 1'b0;
    in_data   = 16'h1234;
    in_valid  = 1'b1;
    resetn    = 1'b0;
    tick();
    tick();
    chk("rst_fout", 32'(fout), 32'h80000);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    resetn   = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'h1);

    // egress fill then drain
    for (int i = 1; i <= 8; i++) begin
      fin = 20'h10000 | 20'(i);
      tick();
    end
    fin = '0;
    chk("fill_full", 32'(fout[16]), 32'h1);
    chk("fill_head", 32'(out_data), 32'h0001);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_empty", 32'(fout[19]), 32'h1);

    // overflow: push while full with a concurrent host pop
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fin = 20'h10000 | 20'(16'h0010 + i);
      tick();
    end
    fin       = 20'h1DEAD;
    out_ready = 1'b1;
    tick();
    fin       = '0;
    out_ready = 1'b0;
    chk("ovf_set", 32'(fout[18]), 32'(OVF_EN));
    chk("ovf_not_full", 32'(fout[16]), 32'h0);
    fin = 20'h40000;
    tick();
    fin = '0;
    chk("ovf_clear", 32'(fout[18]), 32'h0);
    fin = 20'h10018;
    tick();
    chk("ovf_refull", 32'(fout[16]), 32'h1);
    fin = 20'h5BEEF;
    tick();
    fin = '0;
    chk("ovf_set_wins", 32'(fout[18]), 32'(OVF_EN));
    fin = 20'h40000;
    tick();
    fin       = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    out_ready = 1'b0;
    chk("ovf_drained", 32'(out_valid), 32'h0);
    for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
    for (int i = 0; i <= 8; i++) exp_q.push_back(16'h0010 + 16'(i));
    chk("host_rx_len", 32'(host_rx.size()), 32'(exp_q.size()));
    found = 0;
    foreach (host_rx[i]) begin
      if (host_rx[i] == 16'hDEAD || host_rx[i] == 16'hBEEF) found++;
      if (i < exp_q.size()) chk("host_rx_word", 32'(host_rx[i]), 32'(exp_q[i]));
    end
    chk("host_rx_no_dropped", 32'(found), 32'h0);

    // ingress stream
    in_valid = 1'b1;
    in_data  = 16'hA5A5;
    tick();
    in_data = 16'h5A5A;
    tick();
    in_valid = 1'b0;
    chk("ing_head0", 32'(fout[17:0]), 32'h2A5A5);
    fin = 20'h20000;
    tick();
    fin = '0;
    chk("ing_head1", 32'(fout[17:0]), 32'h25A5A);
    fin = 20'h20000;
    tick();
    chk("ing_empty", 32'(fout[17:0]), 32'h00000);
    tick();
    fin = '0;
    chk("ing_extra_pop", 32'(fout[17]), 32'h0);
    in_valid = 1'b1;
    in_data  = 16'h7777;
    tick();
    in_valid = 1'b0;
    chk("ing_after_underpop", 32'(fout[17:0]), 32'h27777);
    fin = 20'h20000;
    tick();
    fin = '0;

    // ingress full, concurrent traffic and wrap
    fab_rx.delete();
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = 16'h0200 + 16'(k);
      tick();
    end
    chk("ing_full_ready", 32'(in_ready), 32'h0);
    in_data = 16'h02FF;
    fin     = 20'h20000;
    tick();
    chk("ing_pop_reopens", 32'(in_ready), 32'h1);
    for (int j = 0; j < 21; j++) begin
      in_data = 16'h0300 + 16'(j);
      tick();
    end
    chk("ing_pushpop_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b0;
    for (int j = 0; j < 7; j++) tick();
    fin = '0;
    chk("ing_wrap_empty", 32'(fout[17]), 32'h0);
    exp_q.delete();
    for (int k = 0; k < 8; k++)  exp_q.push_back(16'h0200 + 16'(k));
    for (int j = 0; j < 21; j++) exp_q.push_back(16'h0300 + 16'(j));
    chk("fab_rx_len", 32'(fab_rx.size()), 32'(exp_q.size()));
    foreach (fab_rx[i]) if (i < exp_q.size()) chk("fab_rx_word", 32'(fab_rx[i]), 32'(exp_q[i]));

    // mid-operation asynchronous reset
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fin     = 20'h10000 | 20'(16'h4000 + k);
      in_data = 16'h5000 + 16'(k);
      tick();
    end
    fin      = '0;
    in_valid = 1'b0;
    chk("pre_rst_fout", 32'(fout), 32'h24000 | 32'h05000);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_fout", 32'(fout), 32'h80000);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_out_data", 32'(out_data), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h0);
    #3 resetn = 1'b1;
    tick();
    chk("post_rst_fout", 32'(fout), 32'h80000);
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
